aprx_fp_cast: RTL and testbench

- Pipelined down-cast unit: converts binary32 operands to binary16alt (1/8/7, bias 127) or binary8 (1/5/2, bias 15).
- Rounding is round-to-nearest-even (RNE), with IEEE-style exception flags.
- Sits directly upstream of the approximate multiplier, so the multiplier receives correctly rounded narrow operands instead of truncated binary32 fields.
- Fully valid/ready handshaked; two-stage pipeline.

---
 rtl/aprx_fp_pkg.sv | 27 ++
 rtl/aprx_fp_cast_if.sv | 15 +
 rtl/aprx_rne_round.sv | 17 +
 rtl/aprx_fp_cast.sv | 157 +++++++++++++++
 tb/tb_aprx_fp_cast.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/aprx_fp_pkg.sv
// aprx_fp_pkg: format constants, operand classes and stage-1 record for aprx_fp_cast.
package aprx_fp_pkg;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MAN_W    = 23;
    localparam int FP32_BIAS     = 127;
    localparam int FP16ALT_EXP_W = 8;
    localparam int FP16ALT_MAN_W = 7;
    localparam int FP16ALT_BIAS  = 127;
    localparam int FP8_EXP_W     = 5;
    localparam int FP8_MAN_W     = 2;
    localparam int FP8_BIAS      = 15;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, QNAN, SNAN} fp_class_e;

    typedef struct packed {
        logic                  sign;
        logic signed [9:0]     te;
        logic [FP32_MAN_W-1:0] man;
        fp_class_e             cls;
        logic                  mode;
    } cast_s1_t;
endpackage

// File: rtl/aprx_fp_cast_if.sv
// aprx_fp_cast_if: operand/result handshake bundle of the down-cast unit.
interface aprx_fp_cast_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c16;
    logic [7:0]  c8;
    logic [3:0]  flags;

    modport master (output in_valid, a, mode, out_ready, input in_ready, out_valid, c16, c8, flags);
    modport slave  (input in_valid, a, mode, out_ready, output in_ready, out_valid, c16, c8, flags);
endinterface

// File: rtl/aprx_rne_round.sv
// aprx_rne_round: round-to-nearest-even on a kept mantissa with guard/sticky bits.
module aprx_rne_round #(
    parameter int KEEP = 7
) (
    input  logic [KEEP-1:0] keep,
    input  logic            guard,
    input  logic            sticky,
    output logic [KEEP-1:0] man,
    output logic            carry,
    output logic            inexact
);
    logic up;

    assign up = guard && (sticky || keep[0]);
    assign {carry, man} = {1'b0, keep} + {{KEEP{1'b0}}, up};
    assign inexact = guard || sticky;
endmodule

// File: rtl/aprx_fp_cast.sv
// aprx_fp_cast: two-stage binary32 -> binary16alt/binary8 RNE down-cast with flags.
// Define APRX_CAST_SUBNORM_EN to produce subnormal results instead of flushing to zero.
module aprx_fp_cast #(
    parameter bit OUT_REG = 1
) (
    input logic clk,
    input logic rst,
    aprx_fp_cast_if.slave bus
);
    import aprx_fp_pkg::*;

    localparam logic signed [9:0] B16   = 10'(FP32_BIAS - FP16ALT_BIAS);
    localparam logic signed [9:0] B8    = 10'(FP32_BIAS - FP8_BIAS);
    localparam logic signed [9:0] EMAX8 = 10'((2 ** FP8_EXP_W) - 2);
    localparam logic [8:0]        EINF16 = 9'((2 ** FP16ALT_EXP_W) - 1);

    cast_s1_t s1, s1_d;
    logic s1_valid, s1_adv, s2_load, ovld;
    logic [FP32_EXP_W-1:0] e;
    logic [FP32_MAN_W-1:0] m;
    logic signed [9:0] te, er1;
    logic [8:0] er0;
    logic [25:0] x;
    logic [FP16ALT_MAN_W-1:0] man0;
    logic [FP8_MAN_W-1:0] man1;
    logic car0, car1, nx0, nx1;
    logic [15:0] r16, o16;
    logic [7:0] r8, o8;
    logic [3:0] rf, of;

    assign e = bus.a[FP32_MAN_W +: FP32_EXP_W];
    assign m = bus.a[FP32_MAN_W-1:0];

    always_comb begin
        s1_d.sign = bus.a[31];
        s1_d.te = $signed({2'b00, e}) - (bus.mode ? B8 : B16);
        s1_d.man = m;
        s1_d.mode = bus.mode;
        s1_d.cls = (e == '0) ? ((m == '0) ? ZERO : SUBN) :
                   (&e) ? ((m == '0) ? INF : (m[22] ? QNAN : SNAN)) : NORM;
    end

    assign s2_load = !ovld || bus.out_ready;
    assign s1_adv = s1_valid && s2_load;
    assign bus.in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_valid <= 1'b0;
            s1 <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            s1 <= s1_d;
        end

    assign te = s1.te;
`ifdef APRX_CAST_SUBNORM_EN
    logic den;
    assign den = (te <= 10'sd0) && (te >= -10'sd2);
    // binary8 denormals shift the hidden bit in; bits falling off the end still feed sticky
    assign x = 26'({1'b1, s1.man, 3'b000} >> (den ? 2'(10'sd1 - te) : 2'd0));
`else
    assign x = {s1.man, 3'b000};
`endif

    aprx_rne_round #(.KEEP(FP16ALT_MAN_W)) u_rnd16 (
        .keep(s1.man[22:16]), .guard(s1.man[15]), .sticky(|s1.man[14:0]),
        .man(man0), .carry(car0), .inexact(nx0)
    );
    aprx_rne_round #(.KEEP(FP8_MAN_W)) u_rnd8 (
        .keep(x[25:24]), .guard(x[23]), .sticky(|x[22:0]),
        .man(man1), .carry(car1), .inexact(nx1)
    );

    assign er0 = {1'b0, te[7:0]} + {8'd0, car0};
    assign er1 = te + $signed({9'd0, car1});

    always_comb begin
        r16 = '0;
        r8 = '0;
        rf = '0;
        if (s1.cls == QNAN || s1.cls == SNAN) begin
            r16 = s1.mode ? 16'h0000 : 16'h7FC0;
            r8 = s1.mode ? 8'h7E : 8'h00;
            rf[FLAG_NV] = (s1.cls == SNAN);
        end else if (s1.cls == INF) begin
            r16 = s1.mode ? 16'h0000 : {s1.sign, 15'h7F80};
            r8 = s1.mode ? {s1.sign, 7'h7C} : 8'h00;
        end else if (s1.cls == ZERO) begin
            r16 = s1.mode ? 16'h0000 : {s1.sign, 15'h0000};
            r8 = s1.mode ? {s1.sign, 7'h00} : 8'h00;
        end else if (!s1.mode) begin
            if (s1.cls == SUBN) begin
`ifdef APRX_CAST_SUBNORM_EN
                r16 = {s1.sign, 7'd0, car0, man0};
                rf[FLAG_UF] = nx0;
                rf[FLAG_NX] = nx0;
`else
                r16 = {s1.sign, 15'h0000};
                rf[FLAG_UF] = 1'b1;
                rf[FLAG_NX] = 1'b1;
`endif
            end else if (er0 == EINF16) begin
                r16 = {s1.sign, 15'h7F80};
                rf[FLAG_OF] = 1'b1;
                rf[FLAG_NX] = 1'b1;
            end else begin
                r16 = {s1.sign, er0[7:0], man0};
                rf[FLAG_NX] = nx0;
            end
        end else if (s1.cls != SUBN && (te > EMAX8 || er1 > EMAX8)) begin
            r8 = {s1.sign, 7'h7C};
            rf[FLAG_OF] = 1'b1;
            rf[FLAG_NX] = 1'b1;
        end else if (s1.cls != SUBN && te >= 10'sd1) begin
            r8 = {s1.sign, er1[4:0], man1};
            rf[FLAG_NX] = nx1;
`ifdef APRX_CAST_SUBNORM_EN
        end else if (s1.cls != SUBN && den) begin
            r8 = {s1.sign, 4'd0, car1, man1};
            rf[FLAG_UF] = nx1;
            rf[FLAG_NX] = nx1;
`endif
        end else begin
            r8 = {s1.sign, 7'h00};
            rf[FLAG_UF] = 1'b1;
            rf[FLAG_NX] = 1'b1;
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    ovld <= 1'b0;
                    o16 <= '0;
                    o8 <= '0;
                    of <= '0;
                end else if (s2_load) begin
                    ovld <= s1_valid;
                    o16 <= r16;
                    o8 <= r8;
                    of <= rf;
                end
        end else begin : g_comb
            assign ovld = s1_valid;
            assign o16 = r16;
            assign o8 = r8;
            assign of = rf;
        end
    endgenerate

    assign bus.out_valid = ovld;
    assign bus.c16 = o16;
    assign bus.c8 = o8;
    assign bus.flags = of;
endmodule

// File: tb/tb_aprx_fp_cast.sv
// tb_aprx_fp_cast: directed vectors for aprx_fp_cast (OUT_REG = 1), incl. stall and reset.
module tb_aprx_fp_cast;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tot = 0;
    int n_bad = 0;

    aprx_fp_cast_if bus ();
    aprx_fp_cast #(.OUT_REG(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef APRX_CAST_SUBNORM_EN
    localparam logic [15:0] SUB16 = 16'h0040;
    localparam logic [3:0]  SUB16F = 4'h0;
    localparam logic [7:0]  SUB8 = 8'h02;
    localparam logic [3:0]  SUB8F = 4'h0;
`else
    localparam logic [15:0] SUB16 = 16'h0000;
    localparam logic [3:0]  SUB16F = 4'h3;
    localparam logic [7:0]  SUB8 = 8'h00;
    localparam logic [3:0]  SUB8F = 4'h3;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic        md;
        logic [15:0] c16;
        logic [7:0]  c8;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [16];
    logic [31:0] ops [4];
    logic [15:0] e16 [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] av, input logic md, output logic [15:0] r16,
                        output logic [7:0] r8, output logic [3:0] rf, output int lat);
        bus.a = av;
        bus.mode = md;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r16 = bus.c16;
        r8 = bus.c8;
        rf = bus.flags;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] r16;
        logic [7:0] r8;
        logic [3:0] rf;
        int lat, sent, got, drop_at;
        logic stale;
        vecs = '{
            '{32'h3F800000, 1'b0, 16'h3F80, 8'h00, 4'h0},
            '{32'h3F808000, 1'b0, 16'h3F80, 8'h00, 4'h1},
            '{32'h3F818000, 1'b0, 16'h3F82, 8'h00, 4'h1},
            '{32'h7F7FFFFF, 1'b0, 16'h7F80, 8'h00, 4'h5},
            '{32'h7FC00000, 1'b0, 16'h7FC0, 8'h00, 4'h0},
            '{32'hFF800000, 1'b0, 16'hFF80, 8'h00, 4'h0},
            '{32'h00400000, 1'b0, SUB16,    8'h00, SUB16F},
            '{32'hC0490FDB, 1'b0, 16'hC049, 8'h00, 4'h1},
            '{32'h7F800001, 1'b0, 16'h7FC0, 8'h00, 4'h8},
            '{32'h3FC00000, 1'b1, 16'h0000, 8'h3E, 4'h0},
            '{32'h47800000, 1'b1, 16'h0000, 8'h7C, 4'h5},
            '{32'hFFA00000, 1'b1, 16'h0000, 8'h7E, 4'h8},
            '{32'h80000000, 1'b1, 16'h0000, 8'h80, 4'h0},
            '{32'h38000000, 1'b1, 16'h0000, SUB8,  SUB8F},
            '{32'h477FFFFF, 1'b1, 16'h0000, 8'h7C, 4'h5},
            '{32'h3F900000, 1'b1, 16'h0000, 8'h3C, 4'h1}
        };
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0800000};
        e16 = '{16'h3F80, 16'h4000, 16'h4040, 16'hC080};
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_c16", bus.c16, 0);
        chk("rst_c8", bus.c8, 0);
        chk("rst_flags", bus.flags, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].a, vecs[i].md, r16, r8, rf, lat);
            if (i == 0) chk("latency", lat, 2);
            chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_c16", i), r16, vecs[i].c16);
            chk($sformatf("v%0d_c8", i), r8, vecs[i].c8);
            chk($sformatf("v%0d_flags", i), rf, vecs[i].fl);
        end
        @(posedge clk);
        #1 chk("drained", bus.out_valid, 0);

        sent = 0;
        got = 0;
        drop_at = -1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            bus.out_ready = (cyc >= 3);
            bus.in_valid = (sent < 4);
            bus.a = (sent < 4) ? ops[sent] : 32'h0;
            bus.mode = 1'b0;
            #1;
            if (!bus.in_ready && drop_at < 0) drop_at = sent;
            if (bus.out_valid && !bus.out_ready) chk($sformatf("hold%0d", got), bus.c16, e16[got]);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("order%0d", got), bus.c16, e16[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("b2b_drop_at", drop_at, 2);
        chk("b2b_count", got, 4);
        stale = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stale |= bus.out_valid;
            @(posedge clk);
            #1;
        end
        chk("b2b_no_dup", stale, 0);

        bus.out_ready = 1'b0;
        bus.mode = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 32'h7F7FFFFF;
        @(posedge clk);
        #1 bus.a = 32'h3F818000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_flags", bus.flags, 4'h5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_flags", bus.flags, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 stale |= bus.out_valid;
            @(posedge clk);
            #1;
        end
        chk("no_stale", stale, 0);
        xfer(32'h3F800000, 1'b0, r16, r8, rf, lat);
        chk("post_rst_c16", r16, 16'h3F80);
        chk("post_rst_lat", lat, 2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
